// File: rtl/axis_pkg.sv
// Shared stream parameters, keep-code constants and arbiter state encoding.
// No logic; pure definitions.
// No flow control; consumed by the arbiter files.
package axis_pkg;

    localparam int DATA_W = 16;
    localparam int KEEP_W = 8;

    // keep counts valid bits, so only whole nibbles are legal codes
    localparam logic [KEEP_W-1:0] KEEP_0  = 8'd0;
    localparam logic [KEEP_W-1:0] KEEP_4  = 8'd4;
    localparam logic [KEEP_W-1:0] KEEP_8  = 8'd8;
    localparam logic [KEEP_W-1:0] KEEP_12 = 8'd12;
    localparam logic [KEEP_W-1:0] KEEP_16 = 8'd16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic logic keep_legal(input logic [KEEP_W-1:0] keep);
        return (keep == KEEP_0) || (keep == KEEP_4) || (keep == KEEP_8) ||
               (keep == KEEP_12) || (keep == KEEP_16);
    endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Bundle of the N_SRC source streams and the single merged stream to the packer.
// No logic; latency belongs to whoever drives the master modport.
// master = arbiter side (drives s_ready and m_*); slave = environment side.
interface axis_pkt_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = axis_pkg::DATA_W,
    parameter int KEEP_W = axis_pkg::KEEP_W
);
    localparam int ID_W = $clog2(N_SRC);

    logic [N_SRC*DATA_W-1:0] s_data;
    logic [N_SRC*KEEP_W-1:0] s_keep;
    logic [N_SRC-1:0]        s_valid;
    logic [N_SRC-1:0]        s_last;
    logic [N_SRC-1:0]        s_ready;

    logic [DATA_W-1:0]       m_data;
    logic [KEEP_W-1:0]       m_keep;
    logic                    m_valid;
    logic                    m_last;
    logic                    m_ready;
    logic [ID_W-1:0]         m_id;

    modport master (
        input  s_data, s_keep, s_valid, s_last,
        output s_ready,
        output m_data, m_keep, m_valid, m_last, m_id,
        input  m_ready
    );

    modport slave (
        output s_data, s_keep, s_valid, s_last,
        input  s_ready,
        input  m_data, m_keep, m_valid, m_last, m_id,
        output m_ready
    );

endinterface

// File: rtl/axis_pkt_arbiter_rr_arbiter.sv
// Rotate-priority pick: first set req bit strictly after last_grant, with wrap.
// Purely combinational, zero cycles.
// No flow control; caller decides when the pick is taken.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any_req
);

    // Walk N positions starting one past last_grant so the previous winner is checked last
    always_comb begin
        int  idx;
        logic found;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin merge of N_SRC streams into one, with keep-code error count.
// Latency: arbitration 1 cycle before first accept; accept -> m_valid 1 cycle.
// Backpressure: one-entry slice; s_ready[grant] = !m_valid | m_ready, full throughput.
module axis_pkt_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = axis_pkg::DATA_W,
    parameter int KEEP_W = axis_pkg::KEEP_W,
    parameter int ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_en,
    axis_pkt_arbiter_if.master   bus,
    output logic                 busy,
    output logic [ERR_W-1:0]     err_cnt
);
    import axis_pkg::*;

    localparam int ID_W = $clog2(N_SRC);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_LOCK = LOCK;

    logic [0:0]        state;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_any;
    logic [N_SRC-1:0]  eligible;

    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_valid;
    logic              sel_last;
    logic              sel_ready;
    logic              accept;

    // src_en only matters while choosing; a running packet ignores it
    assign eligible = bus.s_valid & src_en;

    rr_arbiter #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_rr (
        .req        (eligible),
        .last_grant (last_grant),
        .gnt_idx    (arb_idx),
        .any_req    (arb_any)
    );

    // Steer the granted source onto the slice input and drive its ready
    always_comb begin
        sel_data  = bus.s_data[int'(grant)*DATA_W +: DATA_W];
        sel_keep  = bus.s_keep[int'(grant)*KEEP_W +: KEEP_W];
        sel_valid = bus.s_valid[grant];
        sel_last  = bus.s_last[grant];
        sel_ready = (state == ST_LOCK) && (!bus.m_valid || bus.m_ready);
        bus.s_ready = '0;
        if (sel_ready) begin
            bus.s_ready[grant] = 1'b1;
        end
        accept = sel_ready && sel_valid;
        busy   = (state == ST_LOCK);
    end

    // Grant lock: pick in IDLE, release only on the accepted last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= ID_W'(N_SRC - 1);
        end else if (state == ST_IDLE) begin
            if (arb_any) begin
                grant <= arb_idx;
                state <= ST_LOCK;
            end
        end else begin
            if (accept && sel_last) begin
                last_grant <= grant;
                state      <= ST_IDLE;
            end
        end
    end

    // Output slice: reload on accept, otherwise empty it once the packer takes the beat
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
            bus.m_data  <= '0;
            bus.m_keep  <= '0;
            bus.m_id    <= '0;
        end else if (accept) begin
            bus.m_valid <= 1'b1;
            bus.m_last  <= sel_last;
            bus.m_data  <= sel_data;
            bus.m_keep  <= sel_keep;
            bus.m_id    <= grant;
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
        end
    end

    // Saturating count of accepted beats carrying a non-nibble keep code
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && !keep_legal(sel_keep) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: per-source stimulus queues, per-source expected queues,
// output beats popped against the expected queue of their m_id, plus ordering tables.
module tb_axis_pkt_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0] keep;
        logic [7:0] exp_err;
    } kvec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src_en = 4'hF;
    logic       busy;
    logic [7:0] err_cnt;

    axis_pkt_arbiter_if #(.N_SRC(N), .DATA_W(16), .KEEP_W(8)) intf ();

    axis_pkt_arbiter #(.N_SRC(N), .DATA_W(16), .KEEP_W(8), .ERR_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .src_en  (src_en),
        .bus     (intf),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    beat_t src_q[N][$];
    beat_t exp_q[N][$];
    int    out_ids[$];
    int    out_last[$];
    int    out_cyc[$];
    int    pkt_ids[$];
    int    total = 0;
    int    bad = 0;
    int    cyc_n = 0;
    int    seq_n = 0;
    logic  rst_r = 1'b1;
    logic  mr = 1'b1;
    logic [3:0] en = 4'hF;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++)
            if (src_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_pkt(input int src, input int n, input logic [7:0] kp, input logic [7:0] kl);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {4'(src), 12'(seq_n)};
            seq_n++;
            b.last = (i == n - 1);
            b.keep = b.last ? kl : kp;
            src_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
    endtask

    // One clock: drive at negedge, then evaluate the handshakes that the next posedge will take
    task automatic cyc();
        logic [63:0] d;
        logic [31:0] kp;
        logic [3:0]  v, l;
        beat_t h, e;
        int id;
        @(negedge clk);
        rst = rst_r;
        intf.m_ready = mr;
        src_en = en;
        d = '0; kp = '0; v = '0; l = '0;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                h = src_q[k][0];
                d[k*16 +: 16] = h.data;
                kp[k*8 +: 8]  = h.keep;
                v[k] = 1'b1;
                l[k] = h.last;
            end
        end
        intf.s_data = d; intf.s_keep = kp; intf.s_valid = v; intf.s_last = l;
        #1;
        cyc_n++;
        if (!rst) begin
            check("s_ready_onehot", 64'($countones(intf.s_ready) <= 1), 64'd1);
            for (int k = 0; k < N; k++)
                if (intf.s_valid[k] && intf.s_ready[k]) void'(src_q[k].pop_front());
            if (intf.m_valid && intf.m_ready) begin
                id = int'(intf.m_id);
                total++;
                if (exp_q[id].size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_beat id=%0d data=%0h required=none", id, intf.m_data);
                end else begin
                    e = exp_q[id].pop_front();
                    check("sb_beat", {intf.m_data, intf.m_keep, intf.m_last},
                          {e.data, e.keep, e.last});
                end
                out_ids.push_back(id);
                out_last.push_back(int'(intf.m_last));
                out_cyc.push_back(cyc_n);
                if (intf.m_last) pkt_ids.push_back(id);
            end
        end
    endtask

    task automatic do_reset();
        rst_r = 1'b1;
        mr = 1'b1;
        en = 4'hF;
        for (int k = 0; k < N; k++) begin src_q[k].delete(); exp_q[k].delete(); end
        cyc(); cyc();
        rst_r = 1'b0;
        out_ids.delete(); out_last.delete(); out_cyc.delete(); pkt_ids.delete();
    endtask

    task automatic run_drain(input int max, input string nm);
        int i = 0;
        while (!(all_empty() && !intf.m_valid) && i < max) begin cyc(); i++; end
        check(nm, 64'(all_empty() && !intf.m_valid), 64'd1);
    endtask

    task automatic wait_out(input int n, input int max, input string nm);
        int i = 0;
        while (out_ids.size() < n && i < max) begin cyc(); i++; end
        check(nm, 64'(out_ids.size() >= n), 64'd1);
    endtask

    task automatic wait_pkts(input int n, input int max, input string nm);
        int i = 0;
        while (pkt_ids.size() < n && i < max) begin cyc(); i++; end
        check(nm, 64'(pkt_ids.size() >= n), 64'd1);
    endtask

    task automatic chk_zero(input string nm);
        check(nm, 64'({intf.m_data, intf.m_keep, intf.m_valid, intf.m_last, intf.m_id,
                       busy, err_cnt, intf.s_ready}), 64'd0);
    endtask

    kvec_t kv[7];
    int    exp2_id[6]   = '{0, 0, 0, 2, 2, 2};
    int    exp2_last[6] = '{0, 0, 1, 0, 0, 1};
    logic [63:0] snap;

    initial begin
        kv[0] = '{8'd16, 8'd0};
        kv[1] = '{8'd5,  8'd1};
        kv[2] = '{8'd0,  8'd1};
        kv[3] = '{8'd20, 8'd2};
        kv[4] = '{8'd12, 8'd2};
        kv[5] = '{8'd8,  8'd2};
        kv[6] = '{8'd4,  8'd2};
        intf.m_ready = 1'b1;
        intf.s_data = '0; intf.s_keep = '0; intf.s_valid = '0; intf.s_last = '0;

        // 1: reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_zero("idle_outputs");
        end

        // 2: two simultaneous 3-beat packets from src0 and src2
        do_reset();
        push_pkt(0, 3, 8'd16, 8'd8);
        push_pkt(2, 3, 8'd16, 8'd8);
        run_drain(100, "t2_drain");
        check("t2_beat_count", 64'(out_ids.size()), 64'd6);
        if (out_ids.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t2_m_id", 64'(out_ids[i]), 64'(exp2_id[i]));
                check("t2_m_last", 64'(out_last[i]), 64'(exp2_last[i]));
                if (i > 0)
                    check("t2_beat_spacing", 64'(out_cyc[i] - out_cyc[i-1]), (i == 3) ? 64'd2 : 64'd1);
            end
        end

        // 3: all sources continuously requesting single-beat packets
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) push_pkt(k, 1, 8'd16, 8'd16);
        run_drain(200, "t3_drain");
        check("t3_pkt_count", 64'(pkt_ids.size()), 64'd12);
        for (int i = 0; i < pkt_ids.size(); i++)
            check("t3_rr_order", 64'(pkt_ids[i]), 64'(i % N));

        // 4: downstream stall mid-packet
        do_reset();
        push_pkt(1, 6, 8'd16, 8'd12);
        wait_out(2, 50, "t4_start");
        mr = 1'b0;
        cyc();
        snap = {intf.m_data, intf.m_keep, intf.m_last, 6'(intf.m_id), intf.m_valid};
        check("t4_stall_valid", 64'(intf.m_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t4_stall_stable", {intf.m_data, intf.m_keep, intf.m_last, 6'(intf.m_id), intf.m_valid}, snap);
            check("t4_stall_s_ready", 64'(intf.s_ready), 64'd0);
        end
        mr = 1'b1;
        run_drain(100, "t4_drain");
        check("t4_beat_count", 64'(out_ids.size()), 64'd6);
        check("t4_pkt_count", 64'(pkt_ids.size()), 64'd1);

        // 5: src_en[1] cleared while src1 owns the grant
        do_reset();
        push_pkt(1, 4, 8'd16, 8'd16);
        push_pkt(1, 2, 8'd16, 8'd4);
        wait_out(1, 50, "t5_start");
        en = 4'b1101;
        wait_pkts(1, 50, "t5_first_pkt_done");
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("t5_disabled_busy", 64'(busy), 64'd0);
            check("t5_disabled_s_ready", 64'(intf.s_ready), 64'd0);
        end
        check("t5_no_regrant", 64'(pkt_ids.size()), 64'd1);
        push_pkt(3, 1, 8'd8, 8'd8);
        wait_pkts(2, 50, "t5_src3_pkt");
        if (pkt_ids.size() >= 2) check("t5_src3_id", 64'(pkt_ids[1]), 64'd3);
        en = 4'hF;
        run_drain(100, "t5_drain");
        check("t5_pkt_count", 64'(pkt_ids.size()), 64'd3);
        if (pkt_ids.size() >= 3) check("t5_src1_back", 64'(pkt_ids[2]), 64'd1);

        // 6: keep legality table, saturation, reset mid-packet
        do_reset();
        for (int i = 0; i < 7; i++) begin
            push_pkt(0, 1, kv[i].keep, kv[i].keep);
            run_drain(50, "t6_drain");
            check("t6_err_cnt", 64'(err_cnt), 64'(kv[i].exp_err));
        end
        push_pkt(2, 300, 8'd3, 8'd3);
        run_drain(1000, "t6_sat_drain");
        check("t6_err_saturate", 64'(err_cnt), 64'd255);
        push_pkt(0, 3, 8'd16, 8'd16);
        wait_out(out_ids.size() + 1, 50, "t6_rst_start");
        rst_r = 1'b1;
        for (int k = 0; k < N; k++) begin src_q[k].delete(); exp_q[k].delete(); end
        cyc();
        rst_r = 1'b0;
        cyc();
        chk_zero("t6_mid_pkt_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
